// File: rtl/adder3_arb_defs.sv
// Shared definitions for the round-robin adder arbiter: FSM encoding and datapath widths.
package adder3_arb_defs;

  localparam int OPERAND_W  = 3;
  localparam int OPS_DONE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef logic [OPERAND_W-1:0]  operand_t;
  typedef logic [OPS_DONE_W-1:0] ops_count_t;

endpackage

// File: rtl/adder3_rr_arbiter_if.sv
// Request/response bundle between the requesting units (master) and the arbiter (slave).
interface adder3_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import adder3_arb_defs::*;

  // Operands of requester i occupy bits [3i+2:3i] of req_a / req_b.
  logic [NUM_REQ-1:0]           req_valid;
  logic [OPERAND_W*NUM_REQ-1:0] req_a;
  logic [OPERAND_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]           req_ready;

  logic                         resp_valid;
  logic                         resp_ready;
  logic [ID_W-1:0]              resp_id;
  operand_t                     resp_sum;
  logic                         resp_ovfl;
  ops_count_t                   ops_done;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_ovfl, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_ovfl, ops_done
  );

endinterface

// File: rtl/adder_3_bit.sv
// The shared physical 3-bit ripple adder with carry-in and carry-out.
module adder_3_bit
  import adder3_arb_defs::*;
(
  input  operand_t a,
  input  operand_t b,
  input  logic     cin,
  output operand_t sum,
  output logic     cout
);

  logic [OPERAND_W:0] carry;

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < OPERAND_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[OPERAND_W];
  end

endmodule

// File: rtl/adder3_rr_arbiter.sv
// Round-robin arbiter that time-shares one adder_3_bit among NUM_REQ requesters and
// returns registered, ID-tagged results over a valid/ready response channel.
module adder3_rr_arbiter
  import adder3_arb_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  adder3_rr_arbiter_if.slave  bus
);

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  operand_t        op_a;
  operand_t        op_b;

  logic            grant_en;
  logic            grant;
  logic            handshake;
  pick_t           pick;

  operand_t        add_sum;
  logic            add_cout;

  logic [ID_W-1:0] resp_id_q;
  operand_t        resp_sum_q;
  logic            resp_ovfl_q;
  ops_count_t      ops_done_q;

  // First pending requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                    input logic [ID_W-1:0]    ptr);
    pick_t p;
    int    idx;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!p.found && valid[idx]) begin
        p.found = 1'b1;
        p.id    = ID_W'(idx);
      end
    end
    return p;
  endfunction

  // A result leaving RESP frees the adder, so a new grant may overlap the handshake.
  assign grant_en  = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
  assign pick      = rr_pick(bus.req_valid, rr_ptr);
  assign grant     = grant_en && pick.found && !rst;
  assign handshake = (state_q == RESP) && bus.resp_ready;

  assign bus.req_ready  = grant ? (NUM_REQ'(1) << pick.id) : '0;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_ovfl  = resp_ovfl_q;
  assign bus.ops_done   = ops_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order of the always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d receives a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        if (handshake) begin
          state_d = grant ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      cur_id <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      op_a   <= bus.req_a[OPERAND_W*int'(pick.id) +: OPERAND_W];
      op_b   <= bus.req_b[OPERAND_W*int'(pick.id) +: OPERAND_W];
      cur_id <= pick.id;
      rr_ptr <= ID_W'((int'(pick.id) + 1) % NUM_REQ);
    end
  end

  adder_3_bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result registers load only on the EXEC edge, so they hold through any backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id_q   <= '0;
      resp_sum_q  <= '0;
      resp_ovfl_q <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_id_q   <= cur_id;
      resp_sum_q  <= add_sum;
      resp_ovfl_q <= add_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q <= '0;
    end else if (handshake) begin
      ops_done_q <= ops_done_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder3_rr_arbiter.sv
// Self-checking bench for adder3_rr_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_adder3_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the operation currently being added, the result on offer,
  // the next round-robin start position and the handshake count.
  int m_ptr;
  int m_exec, m_exec_id, m_exec_a, m_exec_b;
  int m_resp, m_resp_id, m_resp_a, m_resp_b;
  int m_done;
  int last_grant;
  int dut_grants[$];

  adder3_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  adder3_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr      = 0;
    m_exec     = 0;
    m_exec_id  = 0;
    m_exec_a   = 0;
    m_exec_b   = 0;
    m_resp     = 0;
    m_resp_id  = 0;
    m_resp_a   = 0;
    m_resp_b   = 0;
    m_done     = 0;
    last_grant = -1;
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b);
    bus.req_valid[i]   = v;
    bus.req_a[3*i +: 3] = 3'(a);
    bus.req_b[3*i +: 3] = 3'(b);
  endtask

  // One clock: check DUT outputs at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step();
    int  win;
    bit  window;
    int  exp_ready;
    @(negedge clk);
    win    = -1;
    window = (m_exec == 0) && ((m_resp == 0) || bus.resp_ready);
    if (window) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (win < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
      end
    end
    exp_ready = (win >= 0) ? (1 << win) : 0;
    check("req_ready", 32'(bus.req_ready), exp_ready);
    check("resp_valid", 32'(bus.resp_valid), m_resp);
    if (m_resp != 0) begin
      check("resp_id", 32'(bus.resp_id), m_resp_id);
      check("resp_sum", 32'(bus.resp_sum), (m_resp_a + m_resp_b) % 8);
      check("resp_ovfl", 32'(bus.resp_ovfl), ((m_resp_a + m_resp_b) >= 8) ? 1 : 0);
    end
    check("ops_done", 32'(bus.ops_done), m_done);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req_ready[k]) dut_grants.push_back(k);
    end

    if (m_resp != 0 && bus.resp_ready) begin
      m_done = (m_done + 1) % 256;
      m_resp = 0;
    end
    if (m_exec != 0) begin
      m_resp    = 1;
      m_resp_id = m_exec_id;
      m_resp_a  = m_exec_a;
      m_resp_b  = m_exec_b;
      m_exec    = 0;
    end
    last_grant = win;
    if (win >= 0) begin
      m_exec    = 1;
      m_exec_id = win;
      m_exec_a  = int'(bus.req_a[3*win +: 3]);
      m_exec_b  = int'(bus.req_b[3*win +: 3]);
      m_ptr     = (win + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_id", 32'(bus.resp_id), 0);
    check("rst_resp_sum", 32'(bus.resp_sum), 0);
    check("rst_resp_ovfl", 32'(bus.resp_ovfl), 0);
    check("rst_ops_done", 32'(bus.ops_done), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    model_clear();
    #2;
    check("por_req_ready", 32'(bus.req_ready), 0);
    check("por_resp_valid", 32'(bus.resp_valid), 0);
    check("por_ops_done", 32'(bus.ops_done), 0);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Single request from requester 2: 3+2.
    bus.resp_ready = 1'b1;
    set_req(2, 1, 3, 2);
    dut_grants.delete();
    step();
    check("single_grant_cnt", 32'(dut_grants.size()), 1);
    set_req(2, 0, 0, 0);
    step();
    check("single_valid", 32'(bus.resp_valid), 1);
    check("single_id", 32'(bus.resp_id), 2);
    check("single_sum", 32'(bus.resp_sum), 5);
    check("single_ovfl", 32'(bus.resp_ovfl), 0);
    step();
    check("single_done", 32'(bus.ops_done), 1);

    // Overflow cases from requester 0, second one issued back-to-back.
    set_req(0, 1, 7, 1);
    step();
    set_req(0, 1, 6, 6);
    step();
    check("ovf_7p1_sum", 32'(bus.resp_sum), 0);
    check("ovf_7p1_ovfl", 32'(bus.resp_ovfl), 1);
    step();
    set_req(0, 0, 0, 0);
    step();
    check("ovf_6p6_sum", 32'(bus.resp_sum), 4);
    check("ovf_6p6_ovfl", 32'(bus.resp_ovfl), 1);
    step();
    check("ovf_done", 32'(bus.ops_done), 3);

    // Fairness: every requester valid from reset, consumer always ready.
    reset_pulse();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, $urandom_range(0, 7), $urandom_range(0, 7));
    dut_grants.delete();
    repeat (11) step();
    check("fair_grant_cnt", 32'(dut_grants.size()), 6);
    if (dut_grants.size() >= 5) begin
      check("fair_g0", 32'(dut_grants[0]), 0);
      check("fair_g1", 32'(dut_grants[1]), 1);
      check("fair_g2", 32'(dut_grants[2]), 2);
      check("fair_g3", 32'(dut_grants[3]), 3);
      check("fair_g4", 32'(dut_grants[4]), 0);
    end
    check("fair_done", 32'(bus.ops_done), 5);
    bus.req_valid = '0;
    repeat (2) step();

    // Backpressure: result held for five cycles while requester 1 waits.
    bus.resp_ready = 1'b0;
    set_req(3, 1, 5, 4);
    step();
    set_req(3, 0, 0, 0);
    step();
    set_req(1, 1, 2, 2);
    repeat (5) step();
    check("bp_id", 32'(bus.resp_id), 3);
    check("bp_sum", 32'(bus.resp_sum), 1);
    check("bp_ovfl", 32'(bus.resp_ovfl), 1);
    dut_grants.delete();
    bus.resp_ready = 1'b1;
    step();
    check("bp_grant_cnt", 32'(dut_grants.size()), 1);
    if (dut_grants.size() == 1) check("bp_grant_id", 32'(dut_grants[0]), 1);
    check("bp_done", 32'(bus.ops_done), 7);
    set_req(1, 0, 0, 0);
    repeat (2) step();

    // Reset while the granted operation is in EXEC.
    set_req(2, 1, 1, 1);
    step();
    reset_pulse();
    set_req(2, 0, 0, 0);
    repeat (2) step();
    check("rmid_done", 32'(bus.ops_done), 0);
    check("rmid_valid", 32'(bus.resp_valid), 0);
    bus.req_valid = '1;
    dut_grants.delete();
    step();
    check("rmid_grant_cnt", 32'(dut_grants.size()), 1);
    if (dut_grants.size() == 1) check("rmid_grant_id", 32'(dut_grants[0]), 0);
    bus.req_valid = '0;
    repeat (2) step();

    // Random traffic: requests come and go, consumer stalls at random.
    for (int c = 0; c < 400; c++) begin
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1, $urandom_range(0, 7), $urandom_range(0, 7));
        end
      end
      step();
      if (last_grant >= 0) begin
        if ($urandom_range(0, 1) == 1) set_req(last_grant, 1, $urandom_range(0, 7), $urandom_range(0, 7));
        else bus.req_valid[last_grant] = 1'b0;
      end
    end

    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
